// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state and owner encodings for mem_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    typedef enum logic {OWNER_IF, OWNER_D} owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: grant selection, data over fetch; MEM_ARB_FAIR_EN adds a starvation counter.
module mem_arb_pick #(
    parameter int STARVE_LIMIT = 4
) (
`ifdef MEM_ARB_FAIR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic en,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt
);

    logic starve;

`ifdef MEM_ARB_FAIR_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign starve = cnt_q == CNT_W'(STARVE_LIMIT);

    // Counts data grants that left a fetch waiting; any fetch grant or uncontested data grant clears it.
    always_comb cnt_d = if_gnt ? '0 : d_gnt ? (if_req ? cnt_q + CNT_W'(1) : '0) : cnt_q;

    always_ff @(posedge clk) cnt_q <= !rst ? '0 : cnt_d;
`else
    assign starve = 1'b0;
`endif

    always_comb begin
        d_gnt  = en && d_req && !(if_req && starve);
        if_gnt = en && if_req && !d_gnt;
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and data ports, one transaction at a time.
// Define MEM_ARB_FAIR_EN to bound fetch starvation at STARVE_LIMIT consecutive data grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              fwd;

    mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT)) u_pick (
`ifdef MEM_ARB_FAIR_EN
        .clk    (clk),
        .rst    (rst),
`endif
        .en     (rst && state_q == S_IDLE),
        .if_req (if_req),
        .d_req  (d_req),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (if_gnt || d_gnt) begin
            state_d = S_REQ;
            owner_d = d_gnt ? OWNER_D : OWNER_IF;
            we_d    = d_gnt && d_we;
            addr_d  = d_gnt ? d_addr : if_addr;
            wdata_d = d_gnt ? d_wdata : '0;
        end else if (state_q == S_REQ && mem_gnt) begin
            state_d = S_WAIT;
        end else if (state_q == S_WAIT && mem_rvalid) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= OWNER_IF;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Responses outside WAIT are stray and dropped.
    assign fwd       = rst && state_q == S_WAIT && mem_rvalid;
    assign if_rvalid = fwd && owner_q == OWNER_IF;
    assign d_rvalid  = fwd && owner_q == OWNER_D;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign mem_req   = state_q == S_REQ;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = state_q != S_IDLE;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a response scoreboard for mem_arbiter.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy;

`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit          is_d;
        bit          chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_rsp(input bit is_d, input bit chk_data, input logic [31:0] data);
        exp_t e;
        e.is_d = is_d;
        e.chk_data = chk_data;
        e.data = data;
        sb.push_back(e);
    endtask

    // Entered just after the grant edge; returns at the first IDLE cycle, before its rising edge.
    task automatic serve(input int gd, input int rd, input logic [31:0] rdata,
                         input logic [31:0] a, input logic we, input logic [31:0] wd);
        for (int i = 0; i < gd; i++) begin
            @(negedge clk);
            mem_gnt = 1'b0;
            #1;
            chk("bp_req_busy_gnts", {mem_req, busy, if_gnt, d_gnt}, 4'b1100);
            chk("bp_addr", mem_addr, a);
        end
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        chk("req_phase", {mem_req, mem_we, busy}, {1'b1, we, 1'b1});
        chk("req_addr", mem_addr, a);
        if (we) chk("req_wdata", mem_wdata, wd);
        for (int i = 0; i < rd; i++) begin
            @(negedge clk);
            mem_gnt = 1'b0;
            #1;
            chk("wait_phase", {mem_req, busy}, 2'b01);
        end
        @(negedge clk);
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata = rdata;
        #1;
        chk("rsp_phase", {mem_req, busy, if_rvalid | d_rvalid}, 3'b011);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("idle_again", {busy, mem_req}, 2'b00);
    endtask

    always @(negedge clk) begin
        #3;
        if (if_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {if_rvalid, d_rvalid}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rvalid_port", {if_rvalid, d_rvalid}, e.is_d ? 2'b01 : 2'b10);
                if (e.chk_data) chk("rdata", e.is_d ? d_rdata : if_rdata, e.data);
            end
        end
    end

    initial begin
        int cnt;
        bit exp_if;
        // Reset: grants suppressed even with requests pending
        if_req = 1'b1;
        d_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", {mem_req, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid, busy}, 7'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        if_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Single load
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        #1;
        chk("load_gnt", {d_gnt, if_gnt}, 2'b10);
        expect_rsp(1'b1, 1'b1, 32'hDEADBEEF);
        @(posedge clk); #1 d_req = 1'b0;
        serve(0, 0, 32'hDEADBEEF, 32'h100, 1'b0, 32'h0);

        // Simultaneous fetch and store: store first
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55;
        #1;
        chk("tie_d_first", {d_gnt, if_gnt}, 2'b10);
        expect_rsp(1'b1, 1'b0, 32'h0);
        @(posedge clk); #1 d_req = 1'b0;
        serve(0, 0, 32'h1234, 32'h200, 1'b1, 32'h55);
        #1;
        chk("tie_if_next", {if_gnt, d_gnt}, 2'b10);
        expect_rsp(1'b0, 1'b1, 32'hCAFEF00D);
        @(posedge clk); #1 if_req = 1'b0;
        serve(0, 0, 32'hCAFEF00D, 32'h0, 1'b0, 32'h0);

        // Memory backpressure with a fetch waiting
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        #1;
        chk("bp_d_gnt", {d_gnt, if_gnt}, 2'b10);
        expect_rsp(1'b1, 1'b1, 32'h11112222);
        @(posedge clk); #1 d_req = 1'b0;
        serve(3, 0, 32'h11112222, 32'h300, 1'b0, 32'h0);
        #1;
        chk("bp_if_gnt", {if_gnt, d_gnt}, 2'b10);
        expect_rsp(1'b0, 1'b1, 32'h33334444);
        @(posedge clk); #1 if_req = 1'b0;
        serve(0, 2, 32'h33334444, 32'h40, 1'b0, 32'h0);

        // Starvation: both requests held continuously
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_if = FAIR && cnt == 4;
            chk("starve_gnt", {if_gnt, d_gnt}, exp_if ? 2'b10 : 2'b01);
            cnt = exp_if ? 0 : cnt + 1;
            expect_rsp(!exp_if, 1'b1, 32'hA0000000 + i);
            @(posedge clk);
            serve(0, 0, 32'hA0000000 + i, exp_if ? 32'h80 : 32'h400, 1'b0, 32'h0);
        end
        if_req = 1'b0;
        d_req = 1'b0;

        // Reset during WAIT, then a late response
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        #1;
        chk("rw_gnt", {d_gnt, if_gnt}, 2'b10);
        @(posedge clk); #1 d_req = 1'b0;
        @(negedge clk);
        mem_gnt = 1'b1;
        #1;
        chk("rw_req", mem_req, 1'b1);
        @(negedge clk);
        mem_gnt = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        #1;
        chk("rw_outs", {mem_req, mem_we, if_gnt, d_gnt, if_rvalid, d_rvalid, busy}, 7'b0);
        chk("rw_addr", mem_addr, 32'h0);
        chk("rw_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        if_req = 1'b1; if_addr = 32'h600;
        #1;
        chk("rw_next_gnt", {if_gnt, d_gnt}, 2'b10);
        expect_rsp(1'b0, 1'b1, 32'h00600600);
        @(posedge clk); #1 if_req = 1'b0;
        serve(1, 1, 32'h00600600, 32'h600, 1'b0, 32'h0);

        // Stray response in IDLE
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata = 32'h5A5A5A5A;
        #1;
        chk("stray_outs", {if_rvalid, d_rvalid, busy, mem_req}, 4'b0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("stray_state", {busy, mem_req}, 2'b00);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h700; d_wdata = 32'h77;
        #1;
        chk("stray_next_gnt", {d_gnt, if_gnt}, 2'b10);
        expect_rsp(1'b1, 1'b0, 32'h0);
        @(posedge clk); #1 d_req = 1'b0;
        serve(0, 0, 32'h0, 32'h700, 1'b1, 32'h77);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
